// File: rtl/adc_spi_pkg.sv
// Shared definitions for the serial ADC responder: the FSM state encoding
// and the default conversion width.
package adc_spi_pkg;

    localparam int DataWidthDefault = 16;

    typedef enum logic [2:0] {
        stIdle      = 3'd0,
        stConvWait  = 3'd1,
        stShiftLow  = 3'd2,
        stShiftHigh = 3'd3,
        stDone      = 3'd4,
        stRelease   = 3'd5
    } adcState_t;

    // Width of a down-counter that must be able to hold the value n.
    function automatic int cntWidth(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/adc_spi_if.sv
// Serial ADC bus: chip select, serial clock and data from the converter.
interface adc_spi_if;

    logic AdcCS_n;
    logic AdcSCLK;
    logic AdcMISO;

    modport master (output AdcCS_n, output AdcSCLK, input AdcMISO);
    modport slave  (input AdcCS_n, input AdcSCLK, output AdcMISO);

endinterface

// File: rtl/adc_spi_shift.sv
// SCLK half-period divider, bit counter and MSB-first shift register,
// sequenced by the FSM in adc_spi_responder.
module adc_spi_shift
    import adc_spi_pkg::*;
#(
    parameter int DataWidth = DataWidthDefault,
    parameter int DivWidth  = 8
) (
    input  logic                 Clk_i,
    input  logic                 Reset_i,
    input  logic                 Start_i,
    input  logic                 Tick_i,
    input  logic                 Sample_i,
    input  logic                 BitDec_i,
    input  logic [DivWidth-1:0]  ClkDiv_i,
    input  logic                 Miso_i,
    output logic                 PhaseEnd_o,
    output logic                 LastBit_o,
    output logic [DataWidth-1:0] Data_o
);

    localparam int BitCntWidth = cntWidth(DataWidth);

    logic [DivWidth-1:0]    divCnt;
    logic [BitCntWidth-1:0] bitCnt;
    logic [DataWidth-1:0]   shiftReg;

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            divCnt   <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
        end else begin
            if (Start_i) begin
                divCnt <= ClkDiv_i;
                bitCnt <= BitCntWidth'(DataWidth);
            end else begin
                // ClkDiv_i is only looked at when a phase expires and reloads.
                if (Tick_i) begin
                    if (divCnt == '0) divCnt <= ClkDiv_i;
                    else              divCnt <= divCnt - DivWidth'(1);
                end
                if (BitDec_i && bitCnt != '0) bitCnt <= bitCnt - BitCntWidth'(1);
            end
            if (Sample_i) shiftReg <= {shiftReg[DataWidth-2:0], Miso_i};
        end
    end

    assign PhaseEnd_o = (divCnt == '0);
    assign LastBit_o  = (bitCnt == BitCntWidth'(1));
    assign Data_o     = shiftReg;

endmodule

// File: rtl/adc_spi_responder.sv
// Serial ADC master: drives CS_n/SCLK, shifts in one conversion result per
// request level and reports it with a single-cycle completion pulse.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int DataWidth = DataWidthDefault,
    parameter int DivWidth  = 8,
    parameter int WaitWidth = 8
) (
    input  logic                 Clk_i,
    input  logic                 Reset_i,
    input  logic                 AdcDoConvert_i,
    output logic                 AdcConvComplete_o,
    output logic [DataWidth-1:0] AdcValue_o,
    input  logic [DivWidth-1:0]  ClkDiv_i,
    input  logic [WaitWidth-1:0] ConvWait_i,
    adc_spi_if.master            Spi,
    output adcState_t            DbgState_o
);

    // Request protocol: AdcDoConvert_i is a level. Dropping it mid-conversion
    // aborts; holding it past the done pulse never starts a second conversion,
    // the level must go low for at least one cycle first.
    adcState_t              state;
    logic [WaitWidth-1:0]   waitCnt;
    logic                   csN;
    logic                   sclk;
    logic                   done;
    logic [DataWidth-1:0]   value;

    logic                   inShift;
    logic                   abortNow;
    logic                   startShift;
    logic                   tick;
    logic                   sample;
    logic                   bitDec;
    logic                   phaseEnd;
    logic                   lastBit;
    logic [DataWidth-1:0]   shiftData;

    assign inShift    = (state == stShiftLow) || (state == stShiftHigh);
    assign abortNow   = !AdcDoConvert_i && ((state == stConvWait) || inShift);
    assign startShift = AdcDoConvert_i && (state == stConvWait) && (waitCnt == '0);
    assign tick       = AdcDoConvert_i && inShift;
    assign sample     = AdcDoConvert_i && (state == stShiftLow) && phaseEnd;
    assign bitDec     = AdcDoConvert_i && (state == stShiftHigh) && phaseEnd && !lastBit;

    adc_spi_shift #(
        .DataWidth (DataWidth),
        .DivWidth  (DivWidth)
    ) shifter (
        .Clk_i      (Clk_i),
        .Reset_i    (Reset_i),
        .Start_i    (startShift),
        .Tick_i     (tick),
        .Sample_i   (sample),
        .BitDec_i   (bitDec),
        .ClkDiv_i   (ClkDiv_i),
        .Miso_i     (Spi.AdcMISO),
        .PhaseEnd_o (phaseEnd),
        .LastBit_o  (lastBit),
        .Data_o     (shiftData)
    );

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state   <= stIdle;
            waitCnt <= '0;
            csN     <= 1'b1;
            sclk    <= 1'b0;
            done    <= 1'b0;
            value   <= '0;
        end else if (abortNow) begin
            state <= stIdle;
            csN   <= 1'b1;
            sclk  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                stIdle: begin
                    csN  <= 1'b1;
                    sclk <= 1'b0;
                    if (AdcDoConvert_i) begin
                        state   <= stConvWait;
                        csN     <= 1'b0;
                        waitCnt <= ConvWait_i;
                    end
                end
                stConvWait: begin
                    if (waitCnt == '0) state   <= stShiftLow;
                    else               waitCnt <= waitCnt - WaitWidth'(1);
                end
                stShiftLow: begin
                    if (phaseEnd) begin
                        state <= stShiftHigh;
                        sclk  <= 1'b1;
                    end
                end
                stShiftHigh: begin
                    if (phaseEnd) begin
                        sclk <= 1'b0;
                        if (lastBit) begin
                            // Outputs are registered on entry so they are valid throughout stDone.
                            state <= stDone;
                            csN   <= 1'b1;
                            done  <= 1'b1;
                            value <= shiftData;
                        end else begin
                            state <= stShiftLow;
                        end
                    end
                end
                stDone: begin
                    state <= stRelease;
                end
                stRelease: begin
                    if (!AdcDoConvert_i) state <= stIdle;
                end
                default: begin
                    state <= stIdle;
                    csN   <= 1'b1;
                    sclk  <= 1'b0;
                end
            endcase
        end
    end

    assign Spi.AdcCS_n       = csN;
    assign Spi.AdcSCLK       = sclk;
    assign AdcConvComplete_o = done;
    assign AdcValue_o        = value;
    assign DbgState_o        = state;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: serial slave model, directed and randomized
// conversions checked against latency/value rules computed in the bench.
module tb_adc_spi_responder;
    import adc_spi_pkg::*;

    localparam int DW    = 16;
    localparam int DivW  = 8;
    localparam int WaitW = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             doConvert = 1'b0;
    logic             convComplete;
    logic [DW-1:0]    adcValue;
    logic [DivW-1:0]  clkDiv = '0;
    logic [WaitW-1:0] convWait = '0;
    adcState_t        dbgState;

    adc_spi_if bus ();

    logic [DW-1:0] slaveWord = '0;
    int            riseCnt = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] lastValue = '0;
    int            checks = 0;
    int            errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    adc_spi_responder #(
        .DataWidth (DW),
        .DivWidth  (DivW),
        .WaitWidth (WaitW)
    ) dut (
        .Clk_i             (clk),
        .Reset_i           (rst),
        .AdcDoConvert_i    (doConvert),
        .AdcConvComplete_o (convComplete),
        .AdcValue_o        (adcValue),
        .ClkDiv_i          (clkDiv),
        .ConvWait_i        (convWait),
        .Spi               (bus),
        .DbgState_o        (dbgState)
    );

    // ---------------- serial slave model ----------------
    function automatic logic misoBit(input logic [DW-1:0] w, input int n);
        if (n < 0 || n >= DW) return 1'b0;
        return w[DW-1-n];
    endfunction

    always @(posedge bus.AdcSCLK) riseCnt = riseCnt + 1;
    always @(negedge bus.AdcCS_n) riseCnt = 0;
    assign bus.AdcMISO = misoBit(slaveWord, riseCnt);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_req(input logic [DW-1:0] word, input int div, input int wt);
        @(negedge clk);
        slaveWord = word;
        clkDiv    = DivW'(div);
        convWait  = WaitW'(wt);
        doConvert = 1'b1;
    endtask

    // Advance until n SCLK rises of the current conversion have been seen.
    task automatic wait_rises(input int n, output int doneErr, output int k);
        doneErr = 0;
        @(posedge clk); #1;
        k = 1;
        while (riseCnt != n && k < 4000) begin
            @(posedge clk); #1;
            k++;
            if (convComplete !== 1'b0) doneErr++;
        end
    endtask

    task automatic run_conv(input logic [DW-1:0] word, input int div, input int wt, input int hold);
        int lat, k, run, runsChecked, phaseErr, valErr, holdErr;
        bit seen, prevSclk, sawHigh;
        logic [DW-1:0] expv;
        lat = wt + 2 + 2 * DW * (div + 1);
        start_req(word, div, wt);
        exp_q.push_back(word);
        k = 0; seen = 0; run = 0; runsChecked = 0; phaseErr = 0; valErr = 0;
        prevSclk = 0; sawHigh = 0;
        while (!seen && k < lat + 40) begin
            @(posedge clk); #1;
            k++;
            if (bus.AdcSCLK !== prevSclk) begin
                if (prevSclk || sawHigh) begin
                    runsChecked++;
                    if (run != div + 1) phaseErr++;
                end
                if (bus.AdcSCLK === 1'b1) sawHigh = 1;
                run = 1;
            end else begin
                run++;
            end
            prevSclk = bus.AdcSCLK;
            if (convComplete === 1'b1) seen = 1;
            else if (adcValue !== lastValue) valErr++;
        end
        check("done_seen", 32'(seen), 1);
        check("done_latency", k, lat);
        check("sclk_rises", riseCnt, DW);
        check("cs_n_at_done", 32'(bus.AdcCS_n), 1);
        check("sclk_at_done", 32'(bus.AdcSCLK), 0);
        check("value_stable_before_done", valErr, 0);
        check("sclk_phase_count", runsChecked, 2 * DW - 1);
        check("sclk_phase_length", phaseErr, 0);
        expv = exp_q.pop_front();
        check("value", 32'(adcValue), 32'(expv));
        lastValue = expv;
        @(posedge clk); #1;
        check("done_one_cycle", 32'(convComplete), 0);
        holdErr = 0;
        repeat (hold + 1) begin
            @(posedge clk); #1;
            if (bus.AdcCS_n !== 1'b1 || convComplete !== 1'b0) holdErr++;
        end
        check("held_request_no_restart", holdErr, 0);
        check("release_state", 32'(dbgState), 32'(stRelease));
        @(negedge clk);
        doConvert = 1'b0;
    endtask

    task automatic abort_conv(input logic [DW-1:0] word, input int div, input int wt, input int abortRise);
        int doneErr, k, postErr;
        start_req(word, div, wt);
        wait_rises(abortRise, doneErr, k);
        check("abort_point_reached", riseCnt, abortRise);
        @(negedge clk);
        doConvert = 1'b0;
        @(posedge clk); #1;
        check("abort_cs_n", 32'(bus.AdcCS_n), 1);
        check("abort_sclk", 32'(bus.AdcSCLK), 0);
        check("abort_state", 32'(dbgState), 32'(stIdle));
        postErr = doneErr;
        repeat (4) begin
            @(posedge clk); #1;
            if (convComplete !== 1'b0) postErr++;
        end
        check("abort_no_done", postErr, 0);
        check("abort_value_kept", 32'(adcValue), 32'(lastValue));
    endtask

    task automatic reset_mid_shift(input logic [DW-1:0] word, input int div, input int wt, input int atRise);
        int doneErr, k;
        start_req(word, div, wt);
        wait_rises(atRise, doneErr, k);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_cs_n", 32'(bus.AdcCS_n), 1);
        check("rst_sclk", 32'(bus.AdcSCLK), 0);
        check("rst_done", 32'(convComplete), 0);
        check("rst_value", 32'(adcValue), 0);
        check("rst_state", 32'(dbgState), 32'(stIdle));
        lastValue = '0;
        @(negedge clk);
        rst = 1'b0;
        doConvert = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [DW-1:0] w;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cs_n", 32'(bus.AdcCS_n), 1);
        check("reset_sclk", 32'(bus.AdcSCLK), 0);
        check("reset_done", 32'(convComplete), 0);
        check("reset_value", 32'(adcValue), 0);
        check("reset_state", 32'(dbgState), 32'(stIdle));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_conv(16'hA5C3, 0, 2, 5);
        abort_conv(16'h1234, 0, 2, 8);
        run_conv(16'h0001, 0, 2, 0);
        run_conv(16'hFFFF, 3, 0, 1);
        run_conv(16'h0000, 3, 0, 1);
        reset_mid_shift(16'hBEEF, 1, 1, 5);

        for (int i = 0; i < 8; i++) begin
            w = DW'($urandom);
            if ($urandom_range(0, 3) == 0)
                abort_conv(w, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(1, DW - 1));
            else
                run_conv(w, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 Parameter DataWidth, default 16: conversion result width and number of serial bits per conversion.
REQ-002 Parameter DivWidth, default 8: width of ClkDiv_i.
REQ-003 Parameter WaitWidth, default 8: width of ConvWait_i.
REQ-004 Clk_i  in  1: single clock; all state changes on rising edge.
REQ-005 Reset_i  in  1: reset, synchronous, active-high.
REQ-006 AdcDoConvert_i  in  1: conversion request level from the sensor-application FSM.
REQ-007 AdcConvComplete_o  out  1: one-cycle pulse that marks AdcValue_o as valid.
REQ-008 AdcValue_o  out  DataWidth: last completed conversion result.
REQ-009 ClkDiv_i  in  DivWidth: SCLK half-period minus one, in Clk_i cycles.
REQ-010 ConvWait_i  in  WaitWidth: conversion time after CS_n falls, minus one, in Clk_i cycles.
REQ-011 AdcCS_n_o  out  1: serial ADC chip select, active low.
REQ-012 AdcSCLK_o  out  1: serial ADC clock, idle low.
REQ-013 AdcMISO_i  in  1: serial ADC data, MSB first, sampled on SCLK rising edge.

Function
REQ-014 The FSM SHALL have six states: stIdle, stConvWait, stShiftLow, stShiftHigh, stDone, stRelease.
REQ-015 In stIdle the block SHALL hold CS_n=1 and SCLK=0; AdcDoConvert_i=1 -> stConvWait, CS_n=0, wait counter loaded with ConvWait_i.
REQ-016 stConvWait SHALL last ConvWait_i+1 cycles, then go to stShiftLow with the divider loaded with ClkDiv_i and the bit counter loaded with DataWidth.
REQ-017 Each stShiftLow and stShiftHigh phase SHALL last ClkDiv_i+1 cycles, with SCLK=0 and SCLK=1 respectively.
REQ-018 On stShiftLow->stShiftHigh the block SHALL shift AdcMISO_i into the LSB of the shift register (shift left).
REQ-019 On stShiftHigh expiry: bit counter=1 -> stDone; otherwise decrement the bit counter and go to stShiftLow.
REQ-020 stDone SHALL last exactly one cycle: CS_n=1, SCLK=0, AdcConvComplete_o=1, AdcValue_o updated to the shift register value; next state stRelease.
REQ-021 stRelease SHALL wait for AdcDoConvert_i=0 before stIdle, so one request level yields exactly one conversion.
REQ-022 Latency: with the request first sampled high in stIdle at cycle t, the stDone pulse SHALL occur at cycle t+ConvWait_i+2+2*DataWidth*(ClkDiv_i+1).
REQ-023 AdcDoConvert_i=0 in stConvWait, stShiftLow or stShiftHigh SHALL abort the conversion: next cycle stIdle, CS_n=1, SCLK=0, no done pulse, AdcValue_o unchanged.
REQ-024 AdcValue_o SHALL change only in stDone or on reset.
REQ-025 ClkDiv_i and ConvWait_i SHALL be sampled only at counter load; changes mid-phase SHALL take effect at the next load.
REQ-026 AdcCS_n_o and AdcSCLK_o SHALL be driven directly by flip-flops (glitch-free).
REQ-027 All counters SHALL be unsigned down-counters that expire at zero and never wrap.

Reset
REQ-028 On Reset_i=1 at a clock edge, regardless of state (including mid-shift): state stIdle, AdcCS_n_o=1, AdcSCLK_o=0, AdcConvComplete_o=0, AdcValue_o=0, shift register and counters 0.
REQ-029 Reset SHALL take priority over every other input.

Structure
REQ-030 Package adc_spi_pkg SHALL hold the state encoding and the DataWidth default.
REQ-031 Sub-module adc_spi_shift SHALL contain the divider, bit counter and shift register; the FSM stays in adc_spi_responder.

Verification
REQ-032 Reset: assert Reset_i during a shift -> next cycle CS_n=1, SCLK=0, done=0, AdcValue_o=0x0000.
REQ-033 ClkDiv_i=0, ConvWait_i=2, slave model returns 0xA5C3, request held -> 16 SCLK rising edges, done pulse at t+36, AdcValue_o=0xA5C3.
REQ-034 Request held high after done -> no CS_n fall until request is low for at least one cycle; the next request with slave 0x0001 -> AdcValue_o=0x0001.
REQ-035 Abort: drop request after the 8th SCLK rise -> CS_n=1 next cycle, no done pulse, AdcValue_o keeps its previous value 0xA5C3.
REQ-036 ClkDiv_i=3, ConvWait_i=0: SCLK high and low phases each exactly 4 cycles; slave 0xFFFF then 0x0000 -> both values captured exactly.
